wbu: RTL and testbench
======================

# wbu

Writeback unit of the multi-cycle RV32E core: the stage directly upstream of the register file. It accepts one retiring instruction at a time from the execute stage over a valid/ready handshake. For loads it issues the data-memory read and aligns and extends the returned word. It then drives the register-file write port (`rf_en`/`rf_waddr`/`rf_wdata`) for exactly one cycle and pulses `commit`.

## Interface
- No parameters. Widths are fixed: data 32, register address 5.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: execute stage presents an instruction.
- `in_ready` out 1: the unit can accept an instruction this cycle.
- `in_rd` in 5: destination register.
- `in_wen` in 1: the instruction writes `rd`.
- `in_is_load` in 1: the instruction is a load.
- `in_funct3` in 3: load width/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101).
- `in_result` in 32: ALU result; for a load, the effective byte address.
- `mem_req_valid` out 1: read request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out 32: word-aligned read address, `{addr[31:2],2'b00}`.
- `mem_rsp_valid` in 1: read data valid.
- `mem_rsp_data` in 32: read word.
- `rf_en` out 1: register-file write enable.
- `rf_waddr` out 5: register-file write address.
- `rf_wdata` out 32: register-file write data.
- `commit` out 1: one-cycle pulse when an instruction retires.
- `misalign` out 1: only with `WBU_MISALIGN_CHECK_EN`; one-cycle pulse on a misaligned load.

## Operation
- FSM states: IDLE, REQ, RESP, WRITE. All outputs are registered or decoded from state plus registers.
- IDLE:
  - `in_ready`=1; all other outputs are 0.
  - On `in_valid`, capture `rd`, `wen`, `funct3`, `in_result[1:0]` and the full result.
  - Non-load: go to WRITE. Load: go to REQ.
- REQ: `mem_req_valid`=1 with the address held stable. On `mem_req_ready`, go to RESP.
- RESP:
  - Wait for `mem_rsp_valid`.
  - On the valid cycle, select the byte/half using `addr[1:0]` (half uses `addr[1]`).
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Store the result into the data register, then go to WRITE.
- Any other `funct3` is treated as LW.
- WRITE:
  - `commit`=1.
  - `rf_en` = `wen && rd!=0`, with `rf_waddr`=`rd` and `rf_wdata`=the data register.
  - Next state is IDLE.
- `in_ready`=0 in REQ, RESP and WRITE. The execute stage must hold its outputs until accepted.
- `mem_rsp_valid` outside RESP is ignored.
- `rf_waddr`/`rf_wdata` are 0 whenever `rf_en`=0.

## Timing
- Reset: state IDLE; all data registers cleared; outputs `in_ready`=1, everything else 0.
- Reset mid-operation (any state): immediate return to IDLE, no write and no commit. A late memory response after release is dropped.
- ALU instruction accepted at edge N: `rf_en`/`commit` high during cycle N+1. `in_ready` returns high in cycle N+2, giving a throughput of 1 per 2 cycles.
- Load accepted at edge N:
  - `mem_req_valid` is high from cycle N+1 until the `mem_req_ready` cycle.
  - After the response edge R, the write occurs in cycle R+1.
  - Minimum latency (ready and response each in their first cycle): write in cycle N+3.
- The request may see back-to-back stalls; the address must not change while `mem_req_valid`=1 and `mem_req_ready`=0.
- `rd`=0 or `wen`=0: `commit` still pulses; `rf_en` stays 0.

## Configuration
- `WBU_MISALIGN_CHECK_EN` defined:
  - The check runs at acceptance. A load is misaligned if it is LH/LHU with `addr[0]`=1, or LW with `addr[1:0]`≠0.
  - A misaligned load skips REQ/RESP and goes straight to WRITE with `rf_en`=0, `commit`=1, `misalign`=1.
  - No memory request is issued.
- `WBU_MISALIGN_CHECK_EN` undefined:
  - The `misalign` port is absent.
  - Low address bits irrelevant to the access width are ignored: LW reads the aligned word, LH selects by `addr[1]`.

## Test plan
- Reset while in RESP, then `mem_rsp_valid`=1 after release:
  - `rf_en`=0 and `commit`=0 throughout.
  - `in_ready`=1 in the first cycle after release.
- ALU write, `rd`=5, result 0xDEADBEEF, `in_valid` for 1 cycle:
  - Next cycle: `rf_en`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF, `commit`=1.
  - `in_ready`=0 that cycle.
- ALU write to `rd`=0:
  - `commit`=1 and `rf_en`=0 in that cycle.
  - `rf_waddr`=0 and `rf_wdata`=0.
- LB at address 0x80000003, response word 0x80FF1234, `mem_req_ready` delayed 2 cycles:
  - `mem_req_addr`=0x80000000 held stable throughout the stall.
  - `rf_wdata`=0xFFFFFF80.
  - The same access as LBU gives 0x00000080.
- LHU at address 0x2, response 0xABCD0000: `rf_wdata`=0x0000ABCD.
- LW at address 0x1:
  - With the macro: no `mem_req_valid`; `misalign`=1, `commit`=1, `rf_en`=0.
  - Without the macro: a request to 0x0 and the full word is written.

Source files
------------

// File: rtl/wbu_if.sv
// wbu_if: bundle of the writeback unit's execute-side, data-memory and
// register-file signals.
// Optional macro: WBU_MISALIGN_CHECK_EN adds the misalign pulse.
// slave  = the writeback unit's view; master = the surrounding core/bench.
interface wbu_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [31:0] in_result;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rf_en;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit;
`ifdef WBU_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  modport slave (
`ifdef WBU_MISALIGN_CHECK_EN
    output misalign,
`endif
    input  in_valid, in_rd, in_wen, in_is_load, in_funct3, in_result,
    output in_ready,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output rf_en, rf_waddr, rf_wdata, commit
  );

  modport master (
`ifdef WBU_MISALIGN_CHECK_EN
    input  misalign,
`endif
    output in_valid, in_rd, in_wen, in_is_load, in_funct3, in_result,
    input  in_ready,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  rf_en, rf_waddr, rf_wdata, commit
  );
endinterface

// File: rtl/wbu.sv
// wbu: writeback unit of the multi-cycle RV32E core. Accepts one retiring
// instruction, performs the data-memory read for loads (align + extend),
// then writes the register file for one cycle and pulses commit.
// Optional macro: WBU_MISALIGN_CHECK_EN -- misaligned LH/LHU/LW loads skip
// memory and retire with rf_en=0 and a misalign pulse.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_valid/in_ready: the execute stage holds its fields stable until accepted.
// mem_req_valid/mem_req_ready: once raised, the request and its address stay
// stable until mem_req_ready. mem_rsp_valid has no ready; it is consumed only
// in RESP and ignored in every other state.
module wbu (
  input  logic       clk,
  input  logic       rst,
  wbu_if.slave       bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  rd_q;
  logic        wen_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lo_q;
  // Holds the ALU result / load address, then the extended load data.
  logic [31:0] res_q;
  logic        mis_d;
  logic        mis_q;
  logic        accept;
  logic        wr_en;

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign dbg_state = state_q;

  // Select and sign/zero-extend the addressed byte or half of a read word.
  function automatic logic [31:0] extend(input logic [2:0]  f3,
                                         input logic [1:0]  lo,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b100:  extend = {24'd0, b};
      3'b101:  extend = {16'd0, h};
      default: extend = w;
    endcase
  endfunction

  // Misalignment decode at acceptance; constant 0 when the check is built out.
  always_comb begin
    mis_d = 1'b0;
`ifdef WBU_MISALIGN_CHECK_EN
    if (bus.in_is_load) begin
      case (bus.in_funct3)
        3'b000, 3'b100: mis_d = 1'b0;
        3'b001, 3'b101: mis_d = bus.in_result[0];
        default:        mis_d = |bus.in_result[1:0];
      endcase
    end
`endif
  end

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d           = state_q;
    bus.in_ready      = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = 32'd0;
    bus.commit        = 1'b0;
    wr_en             = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_is_load && !mis_d) state_d = REQ;
          else                          state_d = WRITE;
        end
      end
      REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {res_q[31:2], 2'b00};
        if (bus.mem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (bus.mem_rsp_valid) state_d = WRITE;
      end
      WRITE: begin
        bus.commit = 1'b1;
        wr_en      = wen_q && (rd_q != 5'd0) && !mis_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register-file port is zeroed whenever no write takes place.
  assign bus.rf_en    = wr_en;
  assign bus.rf_waddr = wr_en ? rd_q  : 5'd0;
  assign bus.rf_wdata = wr_en ? res_q : 32'd0;

`ifdef WBU_MISALIGN_CHECK_EN
  assign bus.misalign = (state_q == WRITE) && mis_q;
`endif

  // Capture the instruction on acceptance; overwrite with load data in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q     <= 5'd0;
      wen_q    <= 1'b0;
      funct3_q <= 3'd0;
      lo_q     <= 2'd0;
      res_q    <= 32'd0;
      mis_q    <= 1'b0;
    end else if (accept) begin
      rd_q     <= bus.in_rd;
      wen_q    <= bus.in_wen;
      funct3_q <= bus.in_funct3;
      lo_q     <= bus.in_result[1:0];
      res_q    <= bus.in_result;
      mis_q    <= mis_d;
    end else if ((state_q == RESP) && bus.mem_rsp_valid) begin
      res_q    <= extend(funct3_q, lo_q, bus.mem_rsp_data);
    end
  end

endmodule

// File: tb/tb_wbu.sv
// tb_wbu: directed bench for the writeback unit. Drivers issue instructions
// and serve memory; expected retirements go into exp_q and a negedge monitor
// pops and compares on every commit.
// Optional macro: WBU_MISALIGN_CHECK_EN selects the matching expectations.
module tb_wbu;
  localparam int EW = 39;  // {misalign, rf_en, rf_waddr, rf_wdata}

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;

  wbu_if bus();

  wbu dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic m, input logic en,
                                         input logic [4:0] a, input logic [31:0] d);
    pack = {m, en, a, d};
  endfunction

  // Monitor: every commit must match the oldest expected retirement.
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    logic          m;
    if (rst && bus.commit === 1'b1) begin
`ifdef WBU_MISALIGN_CHECK_EN
      m = bus.misalign;
`else
      m = 1'b0;
`endif
      act = {m, bus.rf_en, bus.rf_waddr, bus.rf_wdata};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_commit: got %h want none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL retire: got mis=%b en=%b waddr=%0d wdata=%h want mis=%b en=%b waddr=%0d wdata=%h",
                   act[38], act[37], act[36:32], act[31:0], e[38], e[37], e[36:32], e[31:0]);
        end
      end
    end
  end

  // Present one instruction; returns at the negedge after acceptance.
  task automatic issue(input logic [4:0] rd, input logic wen, input logic ld,
                       input logic [2:0] f3, input logic [31:0] res);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got %b want 1", bus.in_ready);
    end
    bus.in_valid   = 1'b1;
    bus.in_rd      = rd;
    bus.in_wen     = wen;
    bus.in_is_load = ld;
    bus.in_funct3  = f3;
    bus.in_result  = res;
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.in_rd      = 5'd0;
    bus.in_wen     = 1'b0;
    bus.in_is_load = 1'b0;
    bus.in_funct3  = 3'd0;
    bus.in_result  = 32'd0;
  endtask

  // Serve one read: stall, accept, respond next cycle. Returns in WRITE.
  task automatic serve(input logic [31:0] exp_addr, input int stall,
                       input logic [31:0] word);
    int n = 0;
    while (bus.mem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < stall; i++) begin
      check("req_valid_stall", {31'd0, bus.mem_req_valid}, 32'd1);
      check("req_addr_stall", bus.mem_req_addr, exp_addr);
      bus.mem_rsp_valid = 1'b1;  // stray response while in REQ
      bus.mem_rsp_data  = 32'h0BAD_0BAD;
      @(negedge clk);
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'd0;
    check("req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
    check("req_addr", bus.mem_req_addr, exp_addr);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("req_dropped", {31'd0, bus.mem_req_valid}, 32'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = word;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'd0;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] req_addr,
                         input int stall, input logic [31:0] word,
                         input logic [31:0] exp_data);
    exp_q.push_back(pack(1'b0, 1'b1, rd, exp_data));
    issue(rd, 1'b1, 1'b1, f3, addr);
    serve(req_addr, stall, word);
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    bus.in_valid      = 1'b0;
    bus.in_rd         = 5'd0;
    bus.in_wen        = 1'b0;
    bus.in_is_load    = 1'b0;
    bus.in_funct3     = 3'd0;
    bus.in_result     = 32'd0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check("rst_req_addr", bus.mem_req_addr, 32'd0);
    check("rst_commit", {31'd0, bus.commit}, 32'd0);
    check("rst_rf_en", {31'd0, bus.rf_en}, 32'd0);
    check("rst_rf_wdata", bus.rf_wdata, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // ALU write, rd=5; retire next cycle, in_ready back the cycle after.
    exp_q.push_back(pack(1'b0, 1'b1, 5'd5, 32'hDEADBEEF));
    issue(5'd5, 1'b1, 1'b0, 3'd0, 32'hDEADBEEF);
    check("alu_in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("alu_in_ready_back", {31'd0, bus.in_ready}, 32'd1);

    // ALU to rd=0 and with wen=0: commit only.
    exp_q.push_back(pack(1'b0, 1'b0, 5'd0, 32'd0));
    issue(5'd0, 1'b1, 1'b0, 3'd0, 32'h12345678);
    exp_q.push_back(pack(1'b0, 1'b0, 5'd0, 32'd0));
    issue(5'd9, 1'b0, 1'b0, 3'd0, 32'h0000_00FF);
    exp_q.push_back(pack(1'b0, 1'b1, 5'd31, 32'h0000_0001));
    issue(5'd31, 1'b1, 1'b0, 3'd0, 32'h0000_0001);

    // Loads: LB/LBU with a 2-cycle request stall, then width/lane variety.
    do_load(5'd1, 3'b000, 32'h8000_0003, 32'h8000_0000, 2, 32'h80FF1234, 32'hFFFFFF80);
    do_load(5'd2, 3'b100, 32'h8000_0003, 32'h8000_0000, 2, 32'h80FF1234, 32'h00000080);
    do_load(5'd3, 3'b101, 32'h0000_0002, 32'h0000_0000, 0, 32'hABCD0000, 32'h0000ABCD);
    do_load(5'd4, 3'b001, 32'h0000_0000, 32'h0000_0000, 1, 32'h12348001, 32'hFFFF8001);
    do_load(5'd6, 3'b001, 32'h0000_0012, 32'h0000_0010, 0, 32'h7FFF0000, 32'h00007FFF);
    do_load(5'd7, 3'b000, 32'h0000_0001, 32'h0000_0000, 0, 32'h00007F00, 32'h0000007F);
    do_load(5'd8, 3'b000, 32'h0000_0102, 32'h0000_0100, 0, 32'h00AB0000, 32'hFFFFFFAB);
    do_load(5'd10, 3'b101, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000F00F, 32'h0000F00F);
    do_load(5'd11, 3'b010, 32'h0000_0100, 32'h0000_0100, 3, 32'hCAFEF00D, 32'hCAFEF00D);
    do_load(5'd12, 3'b011, 32'h0000_0008, 32'h0000_0008, 0, 32'h11223344, 32'h11223344);

    // Load with wen=0: memory still accessed, commit without write.
    exp_q.push_back(pack(1'b0, 1'b0, 5'd0, 32'd0));
    issue(5'd13, 1'b0, 1'b1, 3'b010, 32'h0000_0040);
    serve(32'h0000_0040, 0, 32'h99999999);

    // Misaligned LW at 0x1 and LH at 0x3.
`ifdef WBU_MISALIGN_CHECK_EN
    exp_q.push_back(pack(1'b1, 1'b0, 5'd0, 32'd0));
    issue(5'd14, 1'b1, 1'b1, 3'b010, 32'h0000_0001);
    check("mis_lw_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
    exp_q.push_back(pack(1'b1, 1'b0, 5'd0, 32'd0));
    issue(5'd15, 1'b1, 1'b1, 3'b001, 32'h0000_0003);
    check("mis_lh_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
    @(negedge clk);
    check("mis_pulse_end", {31'd0, bus.misalign}, 32'd0);
`else
    do_load(5'd14, 3'b010, 32'h0000_0001, 32'h0000_0000, 0, 32'h55AA55AA, 32'h55AA55AA);
    do_load(5'd15, 3'b001, 32'h0000_0003, 32'h0000_0000, 0, 32'h80010000, 32'hFFFF8001);
`endif

    // Reset while waiting in RESP, late response after release is dropped.
    issue(5'd16, 1'b1, 1'b1, 3'b010, 32'h0000_0020);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("rst_mid_in_resp", {30'd0, dbg_state}, 32'd2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_commit", {31'd0, bus.commit}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hFEEDFACE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) bus.mem_rsp_valid = 1'b0;
      check("rel_commit", {31'd0, bus.commit}, 32'd0);
      check("rel_rf_en", {31'd0, bus.rf_en}, 32'd0);
      check("rel_in_ready_hold", {31'd0, bus.in_ready}, 32'd1);
    end

    // Normal operation resumes after the aborted load.
    exp_q.push_back(pack(1'b0, 1'b1, 5'd17, 32'hA5A5_0001));
    issue(5'd17, 1'b1, 1'b0, 3'd0, 32'hA5A5_0001);

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
